// File: rtl/rst_ce_pkg.sv
// Shared types and constants for the reset-sequencing / clock-enable generator.
// Holds the sequencer state encoding, a width helper and the default parameters.
package rst_ce_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_POR_CYCLES  = 10;
  localparam int DEF_STAGGER     = 2;
  localparam int DEF_DIV_DEFAULT = 0;

  // Counter/index width for values 0..n-1, never narrower than one bit.
  function automatic int CLOG2_MIN1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_ce_gen_ce_div.sv
// Per-channel clock-enable divider: divisor register, down-counter and strobe flop.
// The strobe period is div+1 cycles once the channel is enabled.
module ce_div #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 0
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [DIV_W-1:0] val,
  output logic             ce
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_DEFAULT);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_reg <= DIV_INIT;
      cnt_reg <= DIV_INIT;
      ce      <= 1'b0;
    end else begin
      if (we) begin
        div_reg <= val;
      end
      // While held, track the divisor (including a same-cycle write) so the
      // first count after release uses the freshest value.
      if (!en) begin
        cnt_reg <= we ? val : div_reg;
        ce      <= 1'b0;
      end else if (cnt_reg == '0) begin
        ce      <= 1'b1;
        cnt_reg <= div_reg;
      end else begin
        ce      <= 1'b0;
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rst_ce_gen.sv
// Power-on reset sequencer with staggered per-channel release and
// programmable clock-enable strobes for every downstream channel.
module rst_ce_gen
  import rst_ce_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int POR_CYCLES  = DEF_POR_CYCLES,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int DIV_DEFAULT = DEF_DIV_DEFAULT
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          soft_rst,
  input  logic                          div_we,
  input  logic [CLOG2_MIN1(NUM_CH)-1:0] div_sel,
  input  logic [DIV_W-1:0]              div_val,
  output logic [NUM_CH-1:0]             rst_out_n,
  output logic [NUM_CH-1:0]             ce_out,
  output logic                          ready
);

  localparam int SEL_W = CLOG2_MIN1(NUM_CH);
  localparam int POR_W = CLOG2_MIN1(POR_CYCLES);
  localparam int STG_W = CLOG2_MIN1(STAGGER);

  localparam logic [POR_W-1:0] POR_LOAD = POR_W'(POR_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LOAD = STG_W'(STAGGER - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  seq_state_e        state_reg;
  logic [POR_W-1:0]  por_cnt_reg;
  logic [STG_W-1:0]  stg_cnt_reg;
  logic [SEL_W-1:0]  ch_reg;
  logic [NUM_CH-1:0] release_now;
  logic [NUM_CH-1:0] div_en;

  always_ff @(posedge clk_in) begin
    if (reset || soft_rst) begin
      state_reg   <= S_HOLD;
      por_cnt_reg <= POR_LOAD;
      stg_cnt_reg <= '0;
      ch_reg      <= '0;
      rst_out_n   <= '0;
      ready       <= 1'b0;
    end else begin
      case (state_reg)
        S_HOLD: begin
          if (por_cnt_reg == '0) begin
            state_reg   <= S_RELEASE;
            ch_reg      <= '0;
            stg_cnt_reg <= '0;
          end else begin
            por_cnt_reg <= por_cnt_reg - 1'b1;
          end
        end
        S_RELEASE: begin
          if (stg_cnt_reg == '0) begin
            rst_out_n <= rst_out_n | release_now;
            if (ch_reg == LAST_CH) begin
              state_reg <= S_RUN;
              ready     <= 1'b1;
            end else begin
              ch_reg      <= ch_reg + SEL_W'(1);
              stg_cnt_reg <= STG_LOAD;
            end
          end else begin
            stg_cnt_reg <= stg_cnt_reg - 1'b1;
          end
        end
        S_RUN: begin
        end
        default: state_reg <= S_HOLD;
      endcase
    end
  end

  // A divider starts counting on the very edge its channel is released, so it
  // sees the release decision rather than the registered reset output.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign release_now[gi] = (state_reg == S_RELEASE) && (stg_cnt_reg == '0) &&
                             (ch_reg == SEL_W'(gi));
    assign div_en[gi] = ~soft_rst & (rst_out_n[gi] | release_now[gi]);

    ce_div #(
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div (
      .clk_in (clk_in),
      .reset  (reset),
      .en     (div_en[gi]),
      .we     (div_we && (div_sel == SEL_W'(gi))),
      .val    (div_val),
      .ce     (ce_out[gi])
    );
  end

endmodule

// File: tb/tb_rst_ce_gen.sv
// Self-checking bench for rst_ce_gen: three parameterisations driven side by side
// and compared every cycle against an edge-time reference model.
module tb_rst_ce_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i  [3];
  logic soft_i [3];
  logic we_i   [3];
  int   sel_i  [3];
  int   val_i  [3];

  logic [1:0] sel0;
  logic [0:0] sel1;
  logic [2:0] sel2;
  logic [7:0] val0;
  logic [3:0] val1;
  logic [2:0] val2;
  assign sel0 = 2'(sel_i[0]);
  assign sel1 = 1'(sel_i[1]);
  assign sel2 = 3'(sel_i[2]);
  assign val0 = 8'(val_i[0]);
  assign val1 = 4'(val_i[1]);
  assign val2 = 3'(val_i[2]);

  logic [3:0] outn0, ce0;
  logic [0:0] outn1, ce1;
  logic [4:0] outn2, ce2;
  logic       rdy0, rdy1, rdy2;

  rst_ce_gen dut0 (
    .clk_in(clk), .reset(rst_i[0]), .soft_rst(soft_i[0]), .div_we(we_i[0]),
    .div_sel(sel0), .div_val(val0), .rst_out_n(outn0), .ce_out(ce0), .ready(rdy0)
  );

  rst_ce_gen #(.NUM_CH(1), .DIV_W(4), .POR_CYCLES(1), .STAGGER(1), .DIV_DEFAULT(1)) dut1 (
    .clk_in(clk), .reset(rst_i[1]), .soft_rst(soft_i[1]), .div_we(we_i[1]),
    .div_sel(sel1), .div_val(val1), .rst_out_n(outn1), .ce_out(ce1), .ready(rdy1)
  );

  rst_ce_gen #(.NUM_CH(5), .DIV_W(3), .POR_CYCLES(3), .STAGGER(3), .DIV_DEFAULT(2)) dut2 (
    .clk_in(clk), .reset(rst_i[2]), .soft_rst(soft_i[2]), .div_we(we_i[2]),
    .div_sel(sel2), .div_val(val2), .rst_out_n(outn2), .ce_out(ce2), .ready(rdy2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic int p_num(int d); case (d) 0: return 4; 1: return 1; default: return 5; endcase endfunction
  function automatic int p_por(int d); case (d) 0: return 10; 1: return 1; default: return 3; endcase endfunction
  function automatic int p_stg(int d); case (d) 0: return 2; 1: return 1; default: return 3; endcase endfunction
  function automatic int p_def(int d); case (d) 0: return 0; 1: return 1; default: return 2; endcase endfunction
  function automatic int p_dw(int d);  case (d) 0: return 8; 1: return 4; default: return 3; endcase endfunction
  function automatic int p_selw(int d); case (d) 0: return 2; 1: return 1; default: return 3; endcase endfunction

  // Reference model: t counts edges since the sequence (re)started; channel k is
  // released at edge POR+k*STAGGER and strobes at absolute edge times.
  int m_t   [3];
  int m_div [3][16];
  int m_nxt [3][16];
  bit m_rst [3][16];
  bit m_ce  [3][16];
  bit m_rdy [3];

  task automatic model_edge(input int d);
    int n;
    int rel;
    int dv [16];
    n = p_num(d);
    for (int k = 0; k < 16; k++) dv[k] = m_div[d][k];
    if (rst_i[d]) begin
      m_t[d] = -1;
      m_rdy[d] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        m_rst[d][k] = 1'b0; m_ce[d][k] = 1'b0; m_div[d][k] = p_def(d);
      end
    end else begin
      if (soft_i[d]) begin
        m_t[d] = -1;
        m_rdy[d] = 1'b0;
        for (int k = 0; k < 16; k++) begin m_rst[d][k] = 1'b0; m_ce[d][k] = 1'b0; end
      end else begin
        m_t[d]++;
        for (int k = 0; k < n; k++) begin
          rel = p_por(d) + k * p_stg(d);
          if (m_t[d] == rel) m_nxt[d][k] = m_t[d] + dv[k];
          m_rst[d][k] = (m_t[d] >= rel);
          m_ce[d][k]  = (m_t[d] >= rel) && (m_t[d] == m_nxt[d][k]);
          if (m_ce[d][k]) m_nxt[d][k] = m_t[d] + 1 + dv[k];
        end
        m_rdy[d] = (m_t[d] >= p_por(d) + (n - 1) * p_stg(d));
      end
      if (we_i[d] && sel_i[d] < n) m_div[d][sel_i[d]] = val_i[d] % (1 << p_dw(d));
    end
  endtask

  function automatic logic [32:0] exp_vec(input int d);
    logic [32:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[k] = m_rst[d][k];
      v[16+k] = m_ce[d][k];
    end
    v[32] = m_rdy[d];
    return v;
  endfunction

  function automatic logic [32:0] get_obs(input int d);
    case (d)
      0: return {rdy0, 16'(ce0), 16'(outn0)};
      1: return {rdy1, 16'(ce1), 16'(outn1)};
      default: return {rdy2, 16'(ce2), 16'(outn2)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_edge(d);
    #1;
    cyc++;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      rst_i[d] = 1'b0; soft_i[d] = 1'b0; we_i[d] = 1'b0; sel_i[d] = 0; val_i[d] = 0;
    end
  endtask

  task automatic test_reset();
    idle_all();
    for (int d = 0; d < 3; d++) rst_i[d] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (get_obs(d) !== 33'd0) begin
          failures++;
          $display("FAIL reset dut%0d cyc=%0d got=%h exp=0", d, cyc, get_obs(d));
        end
      end
    end
  endtask

  task automatic test_defaults();
    int rise [3][5];
    logic [32:0] o;
    for (int d = 0; d < 3; d++) for (int k = 0; k < 5; k++) rise[d][k] = -1;
    idle_all();
    for (int e = 0; e < 30; e++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        o = get_obs(d);
        for (int k = 0; k < p_num(d); k++) if (o[k] && rise[d][k] < 0) rise[d][k] = e;
        checks++;
        if (o !== exp_vec(d)) begin
          failures++;
          $display("FAIL defaults dut%0d cyc=%0d got=%h exp=%h", d, cyc, o, exp_vec(d));
        end
      end
    end
    for (int d = 0; d < 3; d++) for (int k = 0; k < p_num(d); k++) begin
      checks++;
      if (rise[d][k] != p_por(d) + k * p_stg(d)) begin
        failures++;
        $display("FAIL release_edge dut%0d ch%0d got=%0d exp=%0d", d, k, rise[d][k], p_por(d) + k * p_stg(d));
      end
    end
    checks++;
    if (ce0 !== 4'hF) begin
      failures++;
      $display("FAIL ce_div0 got=%b exp=1111", ce0);
    end
  endtask

  task automatic test_divider();
    int first = -1;
    int second = -1;
    soft_i[0] = 1'b1; we_i[0] = 1'b1; sel_i[0] = 1; val_i[0] = 3;
    tick();
    soft_i[0] = 1'b0; we_i[0] = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (ce0[1]) begin
        if (first < 0) first = e;
        else if (second < 0) second = e;
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (get_obs(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL divider dut%0d cyc=%0d got=%h exp=%h", d, cyc, get_obs(d), exp_vec(d));
        end
      end
    end
    checks++;
    if (first != 15 || second != 19) begin
      failures++;
      $display("FAIL div_strobe_edges got=%0d,%0d exp=15,19", first, second);
    end
  endtask

  task automatic test_mid_rewrite();
    bit found = 1'b0;
    int hit1 = -1;
    int hit2 = -1;
    we_i[0] = 1'b1; sel_i[0] = 2; val_i[0] = 5;
    tick();
    we_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ce0[2]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rewrite_wait got=no_strobe exp=strobe_within_20");
    end
    we_i[0] = 1'b1; sel_i[0] = 2; val_i[0] = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) we_i[0] = 1'b0;
      if (ce0[2]) begin
        if (hit1 < 0) hit1 = i;
        else if (hit2 < 0) hit2 = i;
      end
      checks++;
      if (get_obs(0) !== exp_vec(0)) begin
        failures++;
        $display("FAIL rewrite cyc=%0d got=%h exp=%h", cyc, get_obs(0), exp_vec(0));
      end
    end
    checks++;
    if (hit1 != 6 || hit2 != 8) begin
      failures++;
      $display("FAIL rewrite_spacing got=%0d,%0d exp=6,8", hit1, hit2);
    end
  endtask

  task automatic test_soft_restart();
    int rise [4];
    int first = -1;
    for (int k = 0; k < 4; k++) rise[k] = -1;
    soft_i[0] = 1'b1; soft_i[2] = 1'b1;
    tick();
    soft_i[0] = 1'b0; soft_i[2] = 1'b0;
    checks++;
    if ({rdy0, ce0, outn0} !== 9'd0 || {rdy2, ce2, outn2} !== 11'd0) begin
      failures++;
      $display("FAIL soft_clear got=%b/%b exp=0", {rdy0, ce0, outn0}, {rdy2, ce2, outn2});
    end
    for (int e = 0; e < 30; e++) begin
      tick();
      for (int k = 0; k < 4; k++) if (outn0[k] && rise[k] < 0) rise[k] = e;
      if (ce0[1] && first < 0) first = e;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (get_obs(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL soft dut%0d cyc=%0d got=%h exp=%h", d, cyc, get_obs(d), exp_vec(d));
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rise[k] != 10 + 2 * k) begin
        failures++;
        $display("FAIL soft_release ch%0d got=%0d exp=%0d", k, rise[k], 10 + 2 * k);
      end
    end
    checks++;
    if (first != 15) begin
      failures++;
      $display("FAIL soft_div_kept got=%0d exp=15", first);
    end
  endtask

  task automatic test_collisions();
    soft_i[0] = 1'b1;
    tick();
    soft_i[0] = 1'b0;
    for (int e = 0; e <= 13; e++) tick();
    rst_i[0] = 1'b1; we_i[0] = 1'b1; sel_i[0] = 1; val_i[0] = 9;
    tick();
    rst_i[0] = 1'b0; we_i[0] = 1'b0;
    checks++;
    if ({rdy0, ce0, outn0} !== 9'd0) begin
      failures++;
      $display("FAIL reset_collide got=%b exp=0", {rdy0, ce0, outn0});
    end
    for (int e = 0; e < 25; e++) begin
      we_i[1] = 1'b1; sel_i[1] = 1; val_i[1] = $urandom_range(0, 15);
      we_i[2] = 1'b1; sel_i[2] = $urandom_range(5, 7); val_i[2] = $urandom_range(0, 7);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (get_obs(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL collide dut%0d cyc=%0d got=%h exp=%h", d, cyc, get_obs(d), exp_vec(d));
        end
      end
    end
    idle_all();
    checks++;
    if (ce0 !== 4'hF) begin
      failures++;
      $display("FAIL div_default_restored got=%b exp=1111", ce0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 3; d++) begin
        rst_i[d]  = ($urandom_range(0, 299) == 0);
        soft_i[d] = ($urandom_range(0, 59) == 0);
        we_i[d]   = ($urandom_range(0, 7) == 0);
        sel_i[d]  = $urandom_range(0, (1 << p_selw(d)) - 1);
        val_i[d]  = $urandom_range(0, (1 << p_dw(d)) - 1) % 7;
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (get_obs(d) !== exp_vec(d)) begin
          failures++;
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", d, cyc, get_obs(d), exp_vec(d));
        end
      end
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    for (int d = 0; d < 3; d++) rst_i[d] = 1'b1;
    test_reset();
    test_defaults();
    test_divider();
    test_mid_rewrite();
    test_soft_restart();
    test_collisions();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
